// File: rtl/proc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | proc_pkg                                                              |
// | Shared defaults and owner encoding for the memory port arbiter.       |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package proc_pkg;

  localparam int c_addr_w   = 12;
  localparam int c_data_w   = 32;
  localparam int c_max_wait = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DU   = 2'd2
  } owner_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arb_starve_cnt                                                        |
// | Saturating denial counter with clear, freeze and saturation flag.     |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module arb_starve_cnt
  import proc_pkg::*;
#(
  parameter int MAX_WAIT = c_max_wait
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  input  logic freeze,
  output logic sat
);

  localparam int                 c_cnt_w = cnt_width(MAX_WAIT);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_WAIT);

  logic [c_cnt_w-1:0] r_cnt;

  // Freeze outranks clear so a locked DU burst does not reset IF's history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      if (clr) begin
        r_cnt <= '0;
      end else if (inc && (r_cnt != c_max)) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign sat = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_port_arbiter                                                      |
// | Shares one single-port memory between IF (reads) and DU (load/store). |
// | Optional macro ARB_ROUND_ROBIN_EN: alternate winner on contention.    |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W   = c_addr_w,
  parameter int DATA_W   = c_data_w,
  parameter int MAX_WAIT = c_max_wait
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              du_req,
  input  logic              du_we,
  input  logic [ADDR_W-1:0] du_addr,
  input  logic [DATA_W-1:0] du_wdata,
  input  logic              du_lock,
  output logic              du_gnt,
  output logic              du_rvalid,
  output logic [DATA_W-1:0] du_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   w_if_gnt;
  logic   w_du_gnt;
  logic   w_starve_sat;
  logic   w_if_turn;
  logic   r_lock_active;
  owner_t r_rd_tag;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_win <= OWN_IF;
    end else if (w_if_gnt) begin
      r_last_win <= OWN_IF;
    end else if (w_du_gnt) begin
      r_last_win <= OWN_DU;
    end
  end

  assign w_if_turn = (r_last_win == OWN_DU);
`else
  assign w_if_turn = 1'b0;
`endif

  // Lock beats starvation, starvation beats the contention policy.
  always_comb begin
    w_if_gnt = 1'b0;
    w_du_gnt = 1'b0;
    if (rst_n) begin
      if (r_lock_active) begin
        w_du_gnt = du_req;
      end else if (w_starve_sat && if_req) begin
        w_if_gnt = 1'b1;
      end else if (if_req && du_req) begin
        w_if_gnt = w_if_turn;
        w_du_gnt = !w_if_turn;
      end else begin
        w_if_gnt = if_req;
        w_du_gnt = du_req;
      end
    end
  end

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (if_req && !w_if_gnt),
    .clr    (w_if_gnt || !if_req),
    .freeze (r_lock_active),
    .sat    (w_starve_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_active <= 1'b0;
      r_rd_tag      <= OWN_NONE;
    end else begin
      r_lock_active <= du_lock && (r_lock_active || w_du_gnt);
      if (w_if_gnt) begin
        r_rd_tag <= OWN_IF;
      end else if (w_du_gnt && !du_we) begin
        r_rd_tag <= OWN_DU;
      end else begin
        r_rd_tag <= OWN_NONE;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign du_gnt    = w_du_gnt;
  assign mem_en    = w_if_gnt || w_du_gnt;
  assign mem_we    = w_du_gnt && du_we;
  assign mem_addr  = w_if_gnt ? if_addr : (w_du_gnt ? du_addr : '0);
  assign mem_wdata = w_du_gnt ? du_wdata : '0;

  assign if_rvalid = (r_rd_tag == OWN_IF);
  assign du_rvalid = (r_rd_tag == OWN_DU);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign du_rdata  = du_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                   |
// | Directed bench with read-data scoreboard for mem_port_arbiter.        |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        du_req;
  logic        du_we;
  logic [11:0] du_addr;
  logic [31:0] du_wdata;
  logic        du_lock;
  logic        du_gnt;
  logic        du_rvalid;
  logic [31:0] du_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        load_mem;
  logic [31:0] mem [16];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] if_q [$];
  logic [31:0] du_q [$];
  logic [31:0] if_exp;
  logic [31:0] du_exp;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .du_req    (du_req),
    .du_we     (du_we),
    .du_addr   (du_addr),
    .du_wdata  (du_wdata),
    .du_lock   (du_lock),
    .du_gnt    (du_gnt),
    .du_rvalid (du_rvalid),
    .du_rdata  (du_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // Single-port memory: mem[0]=3, mem[i]=0x100+i elsewhere.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'd3 : 32'h100 + 32'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gnt(input logic eif, input logic edu, input string tag);
    chk({tag, ".if_gnt"}, {31'd0, if_gnt}, {31'd0, eif});
    chk({tag, ".du_gnt"}, {31'd0, du_gnt}, {31'd0, edu});
    chk({tag, ".mem_en"}, {31'd0, mem_en}, {31'd0, eif | edu});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic eif, input logic edu, input string tag);
    @(negedge clk);
    gnt(eif, edu, tag);
    adv();
  endtask

  // Scoreboard monitor: every rvalid pops the oldest expected word.
  initial forever begin
    @(negedge clk);
    if (if_rvalid === 1'b1) begin
      checks++;
      if (if_q.size() == 0) begin
        errors++;
        $display("FAIL if_rvalid_unexpected: got rvalid=1 data=%0h expected none", if_rdata);
      end else begin
        if_exp = if_q.pop_front();
        if (if_rdata !== if_exp) begin
          errors++;
          $display("FAIL if_rdata: got %0h expected %0h", if_rdata, if_exp);
        end
      end
    end
    if (du_rvalid === 1'b1) begin
      checks++;
      if (du_q.size() == 0) begin
        errors++;
        $display("FAIL du_rvalid_unexpected: got rvalid=1 data=%0h expected none", du_rdata);
      end else begin
        du_exp = du_q.pop_front();
        if (du_rdata !== du_exp) begin
          errors++;
          $display("FAIL du_rdata: got %0h expected %0h", du_rdata, du_exp);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    load_mem = 1'b1;
    if_req   = 1'b1;
    if_addr  = 12'd0;
    du_req   = 1'b1;
    du_we    = 1'b0;
    du_addr  = 12'd0;
    du_wdata = 32'd0;
    du_lock  = 1'b0;

    // Reset with both requesting: nothing issued.
    repeat (2) begin
      @(negedge clk);
      gnt(1'b0, 1'b0, "reset");
      chk("reset.if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("reset.du_rvalid", {31'd0, du_rvalid}, 32'd0);
      adv();
    end
    load_mem = 1'b0;
    rst_n    = 1'b1;

    // Contention: DU load first, then IF fetch.
    if_addr = 12'd2;
    du_q.push_back(32'd3);
    cyc(1'b0, 1'b1, "t2_du");
    du_req = 1'b0;
    if_q.push_back(32'h102);
    cyc(1'b1, 1'b0, "t2_if");
    if_req = 1'b0;
    cyc(1'b0, 1'b0, "t2_idle");

    // Store then load back.
    du_req = 1'b1; du_we = 1'b1; du_addr = 12'd1; du_wdata = 32'd7;
    @(negedge clk);
    gnt(1'b0, 1'b1, "t3_st");
    chk("t3_st.mem_we", {31'd0, mem_we}, 32'd1);
    chk("t3_st.mem_addr", {20'd0, mem_addr}, 32'd1);
    chk("t3_st.mem_wdata", mem_wdata, 32'd7);
    adv();
    du_we = 1'b0;
    du_q.push_back(32'd7);
    @(negedge clk);
    gnt(1'b0, 1'b1, "t3_ld");
    chk("t3_ld.no_store_rvalid", {31'd0, du_rvalid}, 32'd0);
    adv();
    du_req = 1'b0;
    cyc(1'b0, 1'b0, "t3_idle");

    // Locked read-modify-write on addr 0 while IF waits.
    du_req = 1'b1; du_we = 1'b0; du_addr = 12'd0; du_lock = 1'b1;
    du_q.push_back(32'd3);
    cyc(1'b0, 1'b1, "t4_a");
    if_req = 1'b1; if_addr = 12'd3;
    du_we = 1'b1; du_wdata = 32'd9;
    cyc(1'b0, 1'b1, "t4_b");
    du_req = 1'b0;
    cyc(1'b0, 1'b0, "t4_c");
    du_lock = 1'b0;
    cyc(1'b0, 1'b0, "t4_d");
`ifdef ARB_ROUND_ROBIN_EN
    if_q.push_back(32'h103);
    cyc(1'b1, 1'b0, "t4_release");
    if_req = 1'b0;
`else
    // Counter was frozen at 0 during the lock: four more DU wins, then IF.
    du_req = 1'b1; du_addr = 12'd5; du_wdata = 32'h55;
    repeat (4) cyc(1'b0, 1'b1, "t4_du");
    if_q.push_back(32'h103);
    cyc(1'b1, 1'b0, "t4_starve");
    if_req = 1'b0;

    // Starvation guard twice in a row: counter restarts after each IF win.
    du_addr = 12'd6; if_req = 1'b1; if_addr = 12'd4;
    repeat (2) begin
      repeat (4) cyc(1'b0, 1'b1, "t5_du");
      if_q.push_back(32'h104);
      cyc(1'b1, 1'b0, "t5_if");
    end
    if_req = 1'b0;
`endif
    du_req = 1'b0;
    cyc(1'b0, 1'b0, "t5_idle");

    // Reset releases an active lock.
    du_req = 1'b1; du_we = 1'b1; du_addr = 12'd8; du_wdata = 32'd0; du_lock = 1'b1;
    cyc(1'b0, 1'b1, "t7_lock");
    du_req = 1'b0;
    rst_n  = 1'b0;
    cyc(1'b0, 1'b0, "t7_rst");
    rst_n  = 1'b1;
    if_req = 1'b1; if_addr = 12'd2;
    if_q.push_back(32'h102);
    cyc(1'b1, 1'b0, "t7_if");
    if_req  = 1'b0;
    du_lock = 1'b0;
    cyc(1'b0, 1'b0, "t7_idle");

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin under continuous contention.
    du_req = 1'b1; du_we = 1'b1; du_addr = 12'd7; du_wdata = 32'd1;
    if_req = 1'b1; if_addr = 12'd5;
    repeat (2) begin
      cyc(1'b0, 1'b1, "t6_du");
      if_q.push_back(32'h105);
      cyc(1'b1, 1'b0, "t6_if");
    end
    du_req = 1'b0; if_req = 1'b0;
`endif

    repeat (2) cyc(1'b0, 1'b0, "drain");
    chk("if_q_empty", 32'(if_q.size()), 32'd0);
    chk("du_q_empty", 32'(du_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
